// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared constants and typedefs for the reg_file_sb register bank
package reg_file_pkg;

    localparam int DEF_W      = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_NUM_RD = 2;
    localparam int DEF_AW     = $clog2(DEF_DEPTH);

    // Register 0 is hard-wired to zero when REG_FILE_ZERO_REG_EN is defined
    localparam int ZERO_REG = 0;

    typedef logic [DEF_AW-1:0] reg_addr_t;
    typedef logic [DEF_W-1:0]  reg_data_t;

endpackage

// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - decode/writeback bus of the register bank with master/slave modports
interface reg_file_sb_if
    import reg_file_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NUM_RD = DEF_NUM_RD
) ();
    localparam int AW = $clog2(DEPTH);

    logic [NUM_RD*AW-1:0] RA;
    logic [NUM_RD*W-1:0]  DR;
    logic [NUM_RD-1:0]    RdBusy;
    logic [W-1:0]         Di;
    logic [AW-1:0]        Dir;
    logic                 RegEn;
    logic                 IssueEn;
    logic [AW-1:0]        IssueDir;
    logic                 Stall;
    logic [AW:0]          BusyCnt;

    // Decode/writeback side
    modport master (
        output RA, Di, Dir, RegEn, IssueEn, IssueDir,
        input  DR, RdBusy, Stall, BusyCnt
    );

    // Register bank side
    modport slave (
        input  RA, Di, Dir, RegEn, IssueEn, IssueDir,
        output DR, RdBusy, Stall, BusyCnt
    );

endinterface

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register busy bits, RAW/WAW hazard flags and busy counter (honours REG_FILE_ZERO_REG_EN)
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NUM_RD = DEF_NUM_RD,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_RD*AW-1:0] ra,
    input  logic                 reg_en,
    input  logic [AW-1:0]        dir,
    input  logic                 issue_en,
    input  logic [AW-1:0]        issue_dir,
    output logic [NUM_RD-1:0]    rd_busy,
    output logic                 stall,
    output logic [AW:0]          busy_cnt
);

    logic [DEPTH-1:0] busy;
    logic [AW:0]      cnt;
    logic             issue_ok;
    logic             cnt_inc;
    logic             cnt_dec;

`ifdef REG_FILE_ZERO_REG_EN
    // The zero register never has a pending producer
    assign issue_ok = issue_en && (issue_dir != AW'(ZERO_REG));
`else
    assign issue_ok = issue_en;
`endif

    // Net change of the busy population: a set on an idle register adds one,
    // a clear on a busy register removes one unless a new producer claims it
    always_comb begin
        cnt_inc = issue_ok && !busy[issue_dir];
        cnt_dec = reg_en && busy[dir] && !(issue_ok && (issue_dir == dir));
    end

    // Busy vector and counter; the issue assignment comes last so set wins over clear
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
            cnt  <= '0;
        end else begin
            if (reg_en) begin
                busy[dir] <= 1'b0;
            end
            if (issue_ok) begin
                busy[issue_dir] <= 1'b1;
            end
            cnt <= cnt + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
        end
    end

    // Hazard flags: a same-cycle writeback to the read/issue register resolves it
    always_comb begin
        logic [AW-1:0] a;
        a       = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            a          = ra[i*AW +: AW];
            rd_busy[i] = busy[a] && !(reg_en && (dir == a));
        end
        stall = (|rd_busy) ||
                (issue_en && busy[issue_dir] && !(reg_en && (dir == issue_dir)));
    end

    assign busy_cnt = cnt;

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register bank with write-first bypass and busy scoreboard (optional REG_FILE_ZERO_REG_EN)
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NUM_RD = DEF_NUM_RD
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_sb_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]        regs [DEPTH];
    logic                wr_ok;
    logic [NUM_RD*W-1:0] dr;

`ifdef REG_FILE_ZERO_REG_EN
    // Writes to the zero register are dropped, so it keeps its reset value of 0
    assign wr_ok = bus.RegEn && (bus.Dir != AW'(ZERO_REG));
`else
    assign wr_ok = bus.RegEn;
`endif

    // Storage: full clear on reset, single write port otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs[k] <= '0;
            end
        end else if (wr_ok) begin
            regs[bus.Dir] <= bus.Di;
        end
    end

    // Combinational read ports with write-first bypass
    always_comb begin
        logic [AW-1:0] a;
        a  = '0;
        dr = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            a = bus.RA[i*AW +: AW];
            if (wr_ok && (bus.Dir == a)) begin
                dr[i*W +: W] = bus.Di;
            end else begin
                dr[i*W +: W] = regs[a];
            end
        end
    end

    assign bus.DR = dr;

    reg_scoreboard #(
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD),
        .AW     (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .ra        (bus.RA),
        .reg_en    (bus.RegEn),
        .dir       (bus.Dir),
        .issue_en  (bus.IssueEn),
        .issue_dir (bus.IssueDir),
        .rd_busy   (bus.RdBusy),
        .stall     (bus.Stall),
        .busy_cnt  (bus.BusyCnt)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - self-checking bench for reg_file_sb (vector table, scoreboard queue, corner sequences)
module tb_reg_file_sb;

    localparam int W      = 32;
    localparam int DEPTH  = 32;
    localparam int NUM_RD = 2;
    localparam int AW     = 5;
    localparam int NVEC   = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    reg_file_sb_if #(.W(W), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) bus ();

    reg_file_sb #(.W(W), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic          reg_en;
        logic [AW-1:0] dir;
        logic [W-1:0]  di;
        logic          iss;
        logic [AW-1:0] idir;
        logic [W-1:0]  dr0;
        logic [W-1:0]  dr1;
        logic [1:0]    rdbusy;
        logic          stall;
        logic [AW:0]   cnt;
    } vec_t;

    vec_t vecs [NVEC];
    vec_t exp_q [$];
    int   n_total = 0;
    int   n_pass  = 0;

    function automatic vec_t mk(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                                input logic reg_en, input logic [AW-1:0] dir, input logic [W-1:0] di,
                                input logic iss, input logic [AW-1:0] idir,
                                input logic [W-1:0] dr0, input logic [W-1:0] dr1,
                                input logic [1:0] rdbusy, input logic stall, input logic [AW:0] cnt);
        vec_t v;
        v.ra0 = ra0; v.ra1 = ra1; v.reg_en = reg_en; v.dir = dir; v.di = di;
        v.iss = iss; v.idir = idir; v.dr0 = dr0; v.dr1 = dr1;
        v.rdbusy = rdbusy; v.stall = stall; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.RegEn    = 1'b0;
        bus.IssueEn  = 1'b0;
        bus.Dir      = '0;
        bus.Di       = '0;
        bus.IssueDir = '0;
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        bus.RA = {a1, a0};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t e;
        // ra0 ra1 | RegEn Dir Di | Iss IDir | DR0 DR1 RdBusy Stall BusyCnt
        vecs[0]  = mk(7, 0, 1, 7, 32'h1234_5678, 0, 0, 32'h1234_5678, 0, 2'b00, 0, 0);
        vecs[1]  = mk(7, 7, 0, 0, 0,             0, 0, 32'h1234_5678, 32'h1234_5678, 2'b00, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0,             1, 3, 0, 0, 2'b00, 0, 0);
        vecs[3]  = mk(7, 3, 0, 0, 0,             0, 0, 32'h1234_5678, 0, 2'b10, 1, 1);
        vecs[4]  = mk(3, 3, 1, 3, 32'hA5,        0, 0, 32'hA5, 32'hA5, 2'b00, 0, 1);
        vecs[5]  = mk(7, 3, 0, 0, 0,             0, 0, 32'h1234_5678, 32'hA5, 2'b00, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0,             1, 9, 0, 0, 2'b00, 0, 0);
        vecs[7]  = mk(9, 0, 1, 9, 32'h99,        1, 9, 32'h99, 0, 2'b00, 0, 1);
        vecs[8]  = mk(9, 0, 0, 0, 0,             0, 0, 32'h99, 0, 2'b01, 1, 1);
        vecs[9]  = mk(0, 0, 0, 0, 0,             1, 9, 0, 0, 2'b00, 1, 1);
        vecs[10] = mk(9, 0, 1, 9, 32'h77,        0, 0, 32'h77, 0, 2'b00, 0, 1);
        vecs[11] = mk(9, 0, 0, 0, 0,             0, 0, 32'h77, 0, 2'b00, 0, 0);
        vecs[12] = mk(0, 0, 0, 0, 0,             1, 1, 0, 0, 2'b00, 0, 0);
        vecs[13] = mk(0, 0, 0, 0, 0,             1, 2, 0, 0, 2'b00, 0, 1);
        vecs[14] = mk(0, 0, 0, 0, 0,             1, 4, 0, 0, 2'b00, 0, 2);
        vecs[15] = mk(2, 4, 0, 0, 0,             0, 0, 0, 0, 2'b11, 1, 3);
        vecs[16] = mk(2, 4, 1, 2, 32'h22,        0, 0, 32'h22, 0, 2'b10, 1, 3);
        vecs[17] = mk(1, 2, 0, 0, 0,             0, 0, 0, 32'h22, 2'b01, 1, 2);

        idle_inputs();
        set_ra(0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        set_ra(5, 31);
        @(negedge clk);
        check("reset_dr0", {32'h0, bus.DR[31:0]}, 64'h0);
        check("reset_dr1", {32'h0, bus.DR[63:32]}, 64'h0);
        check("reset_rdbusy", {62'h0, bus.RdBusy}, 64'h0);
        check("reset_stall", {63'h0, bus.Stall}, 64'h0);
        check("reset_cnt", {58'h0, bus.BusyCnt}, 64'h0);
        next_cycle();

        // Vector table: expected record queued when driven, popped when sampled
        for (int v = 0; v < NVEC; v++) begin
            set_ra(vecs[v].ra0, vecs[v].ra1);
            bus.RegEn    = vecs[v].reg_en;
            bus.Dir      = vecs[v].dir;
            bus.Di       = vecs[v].di;
            bus.IssueEn  = vecs[v].iss;
            bus.IssueDir = vecs[v].idir;
            exp_q.push_back(vecs[v]);
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("v%0d_dr0", v), {32'h0, bus.DR[31:0]}, {32'h0, e.dr0});
            check($sformatf("v%0d_dr1", v), {32'h0, bus.DR[63:32]}, {32'h0, e.dr1});
            check($sformatf("v%0d_rdbusy", v), {62'h0, bus.RdBusy}, {62'h0, e.rdbusy});
            check($sformatf("v%0d_stall", v), {63'h0, bus.Stall}, {63'h0, e.stall});
            check($sformatf("v%0d_cnt", v), {58'h0, bus.BusyCnt}, {58'h0, e.cnt});
            next_cycle();
        end
        idle_inputs();
        check("queue_drained", 64'(exp_q.size()), 64'h0);

`ifdef REG_FILE_ZERO_REG_EN
        // Zero register: write and issue to r0 in the same cycle
        bus.RegEn = 1'b1; bus.Dir = 0; bus.Di = 32'hFFFF;
        bus.IssueEn = 1'b1; bus.IssueDir = 0;
        set_ra(0, 0);
        @(negedge clk);
        check("zr_bypass_dr0", {32'h0, bus.DR[31:0]}, 64'h0);
        check("zr_stall_same", {63'h0, bus.Stall}, 64'h0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("zr_dr0", {32'h0, bus.DR[31:0]}, 64'h0);
        check("zr_rdbusy", {62'h0, bus.RdBusy}, 64'h0);
        check("zr_stall", {63'h0, bus.Stall}, 64'h0);
        check("zr_cnt", {58'h0, bus.BusyCnt}, 64'h2);
        next_cycle();
`else
        // Issue every register: counter reaches DEPTH (r1 and r4 already busy)
        for (int k = 0; k < DEPTH; k++) begin
            bus.IssueEn = 1'b1;
            bus.IssueDir = AW'(k);
            next_cycle();
        end
        idle_inputs();
        set_ra(0, 31);
        @(negedge clk);
        check("full_cnt", {58'h0, bus.BusyCnt}, 64'd32);
        check("full_rdbusy", {62'h0, bus.RdBusy}, 64'h3);
        next_cycle();
        // Write back every register with its index
        for (int k = 0; k < DEPTH; k++) begin
            bus.RegEn = 1'b1;
            bus.Dir = AW'(k);
            bus.Di = 32'(k) + 32'h100;
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        check("drain_cnt", {58'h0, bus.BusyCnt}, 64'h0);
        check("drain_stall", {63'h0, bus.Stall}, 64'h0);
        check("drain_dr0", {32'h0, bus.DR[31:0]}, 64'h100);
        check("drain_dr1", {32'h0, bus.DR[63:32]}, 64'h11F);
        next_cycle();
`endif

        // Reset mid-operation: stored data and pending producers are discarded
        bus.RegEn = 1'b1; bus.Dir = 5; bus.Di = 32'hDEAD_BEEF;
        bus.IssueEn = 1'b1; bus.IssueDir = 6;
        next_cycle();
        idle_inputs();
        set_ra(5, 6);
        @(negedge clk);
        check("pre_rst_dr0", {32'h0, bus.DR[31:0]}, 64'hDEAD_BEEF);
        check("pre_rst_rdbusy", {62'h0, bus.RdBusy}, 64'h2);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_dr0", {32'h0, bus.DR[31:0]}, 64'h0);
        check("post_rst_rdbusy", {62'h0, bus.RdBusy}, 64'h0);
        check("post_rst_stall", {63'h0, bus.Stall}, 64'h0);
        check("post_rst_cnt", {58'h0, bus.BusyCnt}, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
